// File: rtl/cache_ctrl.sv
// cache_ctrl -- sequencing controller for a 4-way set-associative cache with
// one data word per line. It holds the tag, valid, dirty and true-LRU state,
// serves one CPU requester, and moves lines to and from main memory over a
// req/ack handshake. The data words live in external per-way arrays that this
// block reads combinationally (da_rdata) and writes through da_we/da_way.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU request (sampled only while idle)
//   cpu_done/hit/rdata      one-cycle completion pulse, hit flag, load data
//   mem_req/we/addr/wdata   memory transfer request (write-back or refill)
//   mem_ack/rdata           transfer complete, refill data in the same cycle
//   da_rdata                all four ways of set da_index, way w at [w*DATA_W +: DATA_W]
//   da_index/way/we/wdata   data-array set index and write port
module cache_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int INDEX_BITS = 4,
  parameter int TAG_W      = ADDR_W - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_done,
  output logic                  cpu_hit,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [4*DATA_W-1:0]   da_rdata,
  output logic [INDEX_BITS-1:0] da_index,
  output logic [1:0]            da_way,
  output logic                  da_we,
  output logic [DATA_W-1:0]     da_wdata
);

  localparam int SETS   = 1 << INDEX_BITS;
  localparam int LINE_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  // Latched request; the byte-offset bits are never needed.
  logic [LINE_W-1:0] line_q, line_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  // Victim chosen in LOOKUP, held for the memory transfers.
  logic [1:0]        vic_way_q, vic_way_d;
  logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
  logic [DATA_W-1:0] vic_data_q, vic_data_d;

  logic              cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  // Per-set bookkeeping.
  logic [TAG_W-1:0] tag_q   [SETS][4];
  logic [TAG_W-1:0] tag_d   [SETS][4];
  logic [3:0]       valid_q [SETS];
  logic [3:0]       valid_d [SETS];
  logic [3:0]       dirty_q [SETS];
  logic [3:0]       dirty_d [SETS];
  logic [1:0]       age_q   [SETS][4];
  logic [1:0]       age_d   [SETS][4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  assign idx     = line_q[INDEX_BITS-1:0];
  assign req_tag = line_q[LINE_W-1:INDEX_BITS];
  assign da_index = idx;

  // Per-way lookup terms for the latched set.
  logic [3:0]        hit_vec, inv_vec, old_vec;
  logic [DATA_W-1:0] way_data [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_way
    assign way_data[gi] = da_rdata[gi*DATA_W +: DATA_W];
    assign hit_vec[gi]  = valid_q[idx][gi] && (tag_q[idx][gi] == req_tag);
    assign inv_vec[gi]  = !valid_q[idx][gi];
    assign old_vec[gi]  = (age_q[idx][gi] == 2'd3);
  end

  // Priority encoders: descending scan leaves the lowest-numbered match.
  logic [1:0] hit_way, inv_way, old_way, vic_sel;
  always_comb begin
    hit_way = 2'd0;
    inv_way = 2'd0;
    old_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 2'(w);
      if (inv_vec[w]) inv_way = 2'(w);
      if (old_vec[w]) old_way = 2'(w);
    end
    vic_sel = (|inv_vec) ? inv_way : old_way;
  end

  // Bookkeeping update requests from the FSM (always for set idx).
  logic       acc_en;      // LRU touch of acc_way
  logic [1:0] acc_way;
  logic       fill_en;     // install: tag, valid, dirty = store
  logic       mark_dirty;  // store hit

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    vic_way_d   = vic_way_q;
    vic_tag_d   = vic_tag_q;
    vic_data_d  = vic_data_q;
    cpu_hit_d   = cpu_hit_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    da_we       = 1'b0;
    da_way      = 2'd0;
    da_wdata    = '0;
    acc_en      = 1'b0;
    acc_way     = 2'd0;
    fill_en     = 1'b0;
    mark_dirty  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          line_d      = cpu_addr[ADDR_W-1:2];
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          state_d     = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (|hit_vec) begin
          acc_en    = 1'b1;
          acc_way   = hit_way;
          cpu_hit_d = 1'b1;
          if (req_we_q) begin
            da_we      = 1'b1;
            da_way     = hit_way;
            da_wdata   = req_wdata_q;
            mark_dirty = 1'b1;
          end else begin
            cpu_rdata_d = way_data[hit_way];
          end
          state_d = S_RESPOND;
        end else begin
          cpu_hit_d  = 1'b0;
          vic_way_d  = vic_sel;
          vic_tag_d  = tag_q[idx][vic_sel];
          vic_data_d = way_data[vic_sel];
          if (valid_q[idx][vic_sel] && dirty_q[idx][vic_sel]) begin
            state_d = S_WRITEBACK;
          end else if (!req_we_q) begin
            state_d = S_REFILL;
          end else begin
            // Clean store miss: allocate without touching memory.
            da_we    = 1'b1;
            da_way   = vic_sel;
            da_wdata = req_wdata_q;
            fill_en  = 1'b1;
            acc_en   = 1'b1;
            acc_way  = vic_sel;
            state_d  = S_RESPOND;
          end
        end
      end

      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, idx, 2'b00};
        mem_wdata = vic_data_q;
        if (mem_ack) begin
          if (req_we_q) begin
            da_we    = 1'b1;
            da_way   = vic_way_q;
            da_wdata = req_wdata_q;
            fill_en  = 1'b1;
            acc_en   = 1'b1;
            acc_way  = vic_way_q;
            state_d  = S_RESPOND;
          end else begin
            state_d = S_REFILL;
          end
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, 2'b00};
        if (mem_ack) begin
          da_we       = 1'b1;
          da_way      = vic_way_q;
          da_wdata    = mem_rdata;
          fill_en     = 1'b1;
          acc_en      = 1'b1;
          acc_way     = vic_way_q;
          cpu_rdata_d = mem_rdata;
          state_d     = S_RESPOND;
        end
      end

      S_RESPOND: begin
        cpu_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Tag/valid/dirty/age next state. True LRU: the touched way becomes age 0
  // and only ways younger than it age by one, so ages stay a permutation.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    if (fill_en) begin
      tag_d[idx][acc_way]   = req_tag;
      valid_d[idx][acc_way] = 1'b1;
      dirty_d[idx][acc_way] = req_we_q;
    end
    if (mark_dirty) begin
      dirty_d[idx][acc_way] = 1'b1;
    end
    if (acc_en) begin
      for (int w = 0; w < 4; w++) begin
        if (2'(w) == acc_way) begin
          age_d[idx][w] = 2'd0;
        end else if (age_q[idx][w] < age_q[idx][acc_way]) begin
          age_d[idx][w] = age_q[idx][w] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      vic_way_q   <= 2'd0;
      vic_tag_q   <= '0;
      vic_data_q  <= '0;
      cpu_hit_q   <= 1'b0;
      cpu_rdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 4'd0;
        dirty_q[s] <= 4'd0;
        for (int w = 0; w < 4; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= 2'(w);
        end
      end
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      vic_way_q   <= vic_way_d;
      vic_tag_q   <= vic_tag_d;
      vic_data_q  <= vic_data_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      age_q       <= age_d;
    end
  end

  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl -- self-checking bench for cache_ctrl. A table of directed
// transactions (request plus hand-computed hit/data/memory-traffic/latency
// expectations) is replayed in order against one evolving cache state, then
// hand-written sequences cover reset mid-refill, stray acks and a held request.
module tb_cache_ctrl;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int INDEX_BITS = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  cpu_req = 1'b0;
  logic                  cpu_we = 1'b0;
  logic [ADDR_W-1:0]     cpu_addr = '0;
  logic [DATA_W-1:0]     cpu_wdata = '0;
  logic                  cpu_done;
  logic                  cpu_hit;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack = 1'b0;
  logic [DATA_W-1:0]     mem_rdata = '0;
  logic [4*DATA_W-1:0]   da_rdata;
  logic [INDEX_BITS-1:0] da_index;
  logic [1:0]            da_way;
  logic                  da_we;
  logic [DATA_W-1:0]     da_wdata;

  always #5 clk = ~clk;

  cache_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .INDEX_BITS(INDEX_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .da_rdata(da_rdata), .da_index(da_index), .da_way(da_way),
    .da_we(da_we), .da_wdata(da_wdata)
  );

  // External per-way data arrays.
  logic [DATA_W-1:0] da_mem [16][4];
  always_comb begin
    da_rdata = '0;
    for (int w = 0; w < 4; w++) da_rdata[w*DATA_W +: DATA_W] = da_mem[da_index][w];
  end
  always @(posedge clk) begin
    if (da_we) da_mem[da_index][da_way] <= da_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          delay;      // cycles of mem_req before mem_ack
    logic [31:0] mrdata;
    logic        exp_hit;
    logic [31:0] exp_rdata;  // checked for loads only
    logic        exp_wb;
    logic [15:0] exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic        exp_rf;
    logic [15:0] exp_rf_addr;
    int          exp_lat;    // cycles from accept edge to the cpu_done cycle
  } vec_t;

  function automatic vec_t mk(logic we, logic [15:0] addr, logic [31:0] wdata, int delay,
                              logic [31:0] mrdata, logic exp_hit, logic [31:0] exp_rdata,
                              logic exp_wb, logic [15:0] wba, logic [31:0] wbd,
                              logic exp_rf, logic [15:0] rfa, int lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.delay = delay; v.mrdata = mrdata;
    v.exp_hit = exp_hit; v.exp_rdata = exp_rdata;
    v.exp_wb = exp_wb; v.exp_wb_addr = wba; v.exp_wb_data = wbd;
    v.exp_rf = exp_rf; v.exp_rf_addr = rfa; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic        done_seen = 1'b0;
    logic        got_hit = 1'b0;
    logic [31:0] got_rdata = '0;
    logic        wb_seen = 1'b0;
    logic        rf_seen = 1'b0;
    logic [15:0] wb_addr = '0;
    logic [15:0] rf_addr = '0;
    logic [31:0] wb_data = '0;
    logic        pend = 1'b0;
    logic        unstable = 1'b0;
    logic [15:0] p_addr = '0;
    logic        p_we = 1'b0;
    logic [31:0] p_wdata = '0;
    logic        req_at_done = 1'b0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          cnt = 0;
    int          exp_req;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    mem_rdata = v.mrdata;
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 1;
    while (cyc <= 80) begin
      if (cpu_done) begin
        done_seen = 1'b1; got_hit = cpu_hit; got_rdata = cpu_rdata; req_at_done = mem_req;
        break;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
          unstable = 1'b1;
        req_cyc++;
        if (mem_we) begin
          wb_seen = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata;
        end else begin
          rf_seen = 1'b1; rf_addr = mem_addr;
        end
        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        if (cnt == v.delay) begin
          mem_ack = 1'b1; cnt = 0; pend = 1'b0;
        end else begin
          cnt++; pend = 1'b1;
        end
      end else begin
        pend = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    exp_req = (v.exp_wb ? v.delay + 1 : 0) + (v.exp_rf ? v.delay + 1 : 0);
    $display("txn %0d %s addr=%04h hit=%0d rdata=%08h wb=%0d rf=%0d lat=%0d",
             id, v.we ? "ST" : "LD", v.addr, got_hit, got_rdata, wb_seen, rf_seen, cyc);
    chk($sformatf("v%0d done", id), done_seen, 1'b1);
    chk($sformatf("v%0d latency", id), cyc, v.exp_lat);
    chk($sformatf("v%0d hit", id), got_hit, v.exp_hit);
    if (!v.we) chk($sformatf("v%0d rdata", id), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d wb_seen", id), wb_seen, v.exp_wb);
    if (v.exp_wb) begin
      chk($sformatf("v%0d wb_addr", id), wb_addr, v.exp_wb_addr);
      chk($sformatf("v%0d wb_data", id), wb_data, v.exp_wb_data);
    end
    chk($sformatf("v%0d rf_seen", id), rf_seen, v.exp_rf);
    if (v.exp_rf) chk($sformatf("v%0d rf_addr", id), rf_addr, v.exp_rf_addr);
    chk($sformatf("v%0d mem_req cycles", id), req_cyc, exp_req);
    chk($sformatf("v%0d mem stable", id), unstable, 1'b0);
    chk($sformatf("v%0d mem_req at done", id), req_at_done, 1'b0);
  endtask

  function automatic logic [127:0] all_outs();
    return {9'd0, cpu_done, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
            da_we, da_way, da_wdata};
  endfunction

  vec_t vecs[21];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic        bad;
    int          dcnt;
    logic        held_hit;
    logic [31:0] held_rdata;

    // Set-0 addresses: tag = addr>>6. Ages start [w0..w3] = [0,1,2,3].
    vecs[0]  = mk(0, 16'h0000, 0, 3, 32'hAAAA0001, 0, 32'hAAAA0001, 0, 0, 0, 1, 16'h0000, 6);
    vecs[1]  = mk(0, 16'h0000, 0, 0, 0,            1, 32'hAAAA0001, 0, 0, 0, 0, 0,        2);
    vecs[2]  = mk(1, 16'h0040, 32'h1234, 0, 0,     0, 0,            0, 0, 0, 0, 0,        2);
    vecs[3]  = mk(0, 16'h0080, 0, 0, 32'hBBBB0002, 0, 32'hBBBB0002, 0, 0, 0, 1, 16'h0080, 3);
    vecs[4]  = mk(0, 16'h00C0, 0, 1, 32'hCCCC0003, 0, 32'hCCCC0003, 0, 0, 0, 1, 16'h00C0, 4);
    vecs[5]  = mk(0, 16'h0040, 0, 0, 0,            1, 32'h1234,     0, 0, 0, 0, 0,        2);
    vecs[6]  = mk(0, 16'h0000, 0, 0, 0,            1, 32'hAAAA0001, 0, 0, 0, 0, 0,        2);
    // Ages now [0,1,3,2]: way 2 (0x0080, clean) is the victim.
    vecs[7]  = mk(0, 16'h0100, 0, 2, 32'hDDDD0004, 0, 32'hDDDD0004, 0, 0, 0, 1, 16'h0100, 5);
    vecs[8]  = mk(0, 16'h00C0, 0, 0, 0,            1, 32'hCCCC0003, 0, 0, 0, 0, 0,        2);
    // Ages [2,3,1,0]: way 1 (0x0040, dirty 0x1234) is written back first.
    vecs[9]  = mk(0, 16'h0140, 0, 1, 32'hEEEE0005, 0, 32'hEEEE0005, 1, 16'h0040, 32'h1234, 1, 16'h0140, 6);
    vecs[10] = mk(0, 16'h0140, 0, 0, 0,            1, 32'hEEEE0005, 0, 0, 0, 0, 0,        2);
    vecs[11] = mk(1, 16'h0140, 32'h5555, 0, 0,     1, 0,            0, 0, 0, 0, 0,        2);
    vecs[12] = mk(0, 16'h0140, 0, 0, 0,            1, 32'h5555,     0, 0, 0, 0, 0,        2);
    vecs[13] = mk(0, 16'h0040, 0, 0, 32'h1234,     0, 32'h1234,     0, 0, 0, 1, 16'h0040, 3);
    vecs[14] = mk(1, 16'h0180, 32'h7777, 0, 0,     0, 0,            0, 0, 0, 0, 0,        2);
    vecs[15] = mk(0, 16'h01C0, 0, 0, 32'hFFFF0007, 0, 32'hFFFF0007, 0, 0, 0, 1, 16'h01C0, 3);
    // Store miss evicting dirty way 1 (0x0140 = 0x5555): write-back, no refill.
    vecs[16] = mk(1, 16'h0240, 32'h9999, 1, 0,     0, 0,            1, 16'h0140, 32'h5555, 0, 0, 4);
    vecs[17] = mk(0, 16'h0240, 0, 0, 0,            1, 32'h9999,     0, 0, 0, 0, 0,        2);
    vecs[18] = mk(0, 16'h0180, 0, 0, 0,            1, 32'h7777,     0, 0, 0, 0, 0,        2);
    // Set 1 is independent of set 0.
    vecs[19] = mk(0, 16'h0004, 0, 0, 32'h11110001, 0, 32'h11110001, 0, 0, 0, 1, 16'h0004, 3);
    vecs[20] = mk(0, 16'h0004, 0, 0, 0,            1, 32'h11110001, 0, 0, 0, 0, 0,        2);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset outputs", all_outs(), 128'd0);
    chk("reset cpu_done", cpu_done, 1'b0);
    chk("reset mem_req", mem_req, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // Reset asserted while a refill is outstanding.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0008; mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_req && !mem_we) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst refill reached", seen, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst outputs", all_outs(), 128'd0);
    reset = 1'b1;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_done) dcnt++;
    end
    chk("rst dropped no done", dcnt, 0);
    $display("txn rst reset during refill, done_count=%0d", dcnt);
    // Tags were cleared, so 0x0000 misses again.
    run_vec(mk(0, 16'h0000, 0, 1, 32'hAAAA0001, 0, 32'hAAAA0001, 0, 0, 0, 1, 16'h0000, 4), 21);

    // Stray acks while idle.
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_req || cpu_done || da_we) bad = 1'b1;
      mem_ack = 1'b1;
    end
    @(negedge clk);
    if (mem_req || cpu_done || da_we) bad = 1'b1;
    mem_ack = 1'b0;
    chk("idle ack ignored", bad, 1'b0);
    $display("txn idle_ack ignored=%0d", !bad);

    // cpu_req held through LOOKUP and RESPOND, with mem_ack asserted too.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; mem_ack = 1'b1;
    dcnt = 0; held_hit = 1'b0; held_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done) begin
        dcnt++; held_hit = cpu_hit; held_rdata = cpu_rdata;
      end
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_done) dcnt++;
    end
    chk("held req done count", dcnt, 1);
    chk("held req hit", held_hit, 1'b1);
    chk("held req rdata", held_rdata, 32'hAAAA0001);
    $display("txn held_req done_count=%0d hit=%0d rdata=%08h", dcnt, held_hit, held_rdata);

    run_vec(mk(0, 16'h0000, 0, 0, 0, 1, 32'hAAAA0001, 0, 0, 0, 0, 0, 2), 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
